// File: rtl/mips_pkg.sv
// Shared types and width constants for the memory-stage controller slice.
package mips_pkg;

   localparam int WORD_W     = 32;
   localparam int ADDR_W_DEF = 32;
   localparam int BYTE_OFF_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/ack bus between the memory-stage controller (master) and data memory (slave).
interface mem_stage_ctrl_if
   import mips_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = WORD_W
);
   logic              memReq;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWData;
   logic              memAck;
   logic [DATA_W-1:0] memRData;

   modport master (
      output memReq, memWe, memAddr, memWData,
      input  memAck, memRData
   );

   modport slave (
      input  memReq, memWe, memAddr, memWData,
      output memAck, memRData
   );
endinterface

// File: rtl/store_buffer.sv
// One-entry posted-store buffer with address-match lookup; capture wins over clear
// so a store accepted in the drain-ack cycle replaces the entry being retired.
module store_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture,
   input  logic              clear,
   input  logic [ADDR_W-1:0] cap_addr,
   input  logic [DATA_W-1:0] cap_data,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              valid,
   output logic [ADDR_W-1:0] sb_addr,
   output logic [DATA_W-1:0] sb_data,
   output logic              hit
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
      end
      if (capture) begin
         valid_d = 1'b1;
         addr_d  = cap_addr;
         data_d  = cap_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign valid   = valid_q;
   assign sb_addr = addr_q;
   assign sb_data = data_q;
   assign hit     = valid_q && (addr_q == lookup_addr);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: posts stores, forwards buffered data, stalls on reads.
// state | meaning
// IDLE  | no bus activity; load hits served from the buffer
// DRAIN | writing the buffered store to memory
// READ  | load miss waiting for read data
// DONE  | load result presented, pipeline advances
module mem_stage_ctrl
   import mips_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = WORD_W,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wData,
   output logic              stall,
   output logic [DATA_W-1:0] ldData,
   output logic              misalign,
   output logic              busErr,
   mem_stage_ctrl_if.master  mem
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   mem_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] ld_q, ld_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              mis_raw, ld, st, in_drain, in_read, ack, tmo;
   logic              accept, capture, sb_clear;
   logic              sb_valid, sb_hit;
   logic [ADDR_W-1:0] sb_addr, sb_addr_nxt;
   logic [DATA_W-1:0] sb_data, sb_data_nxt;

   assign mis_raw  = (memRead || memWrite) && (addr[BYTE_OFF_W-1:0] != '0);
   assign ld       = memRead && !mis_raw;
   assign st       = memWrite && !mis_raw;
   assign in_drain = (state_q == DRAIN);
   assign in_read  = (state_q == READ);
   assign ack      = mem.memAck;
   // An ack arriving in the timeout cycle completes the transaction normally.
   assign tmo      = (in_drain || in_read) && (cnt_q == TMO_LAST) && !ack;
   assign accept   = !sb_valid || (in_drain && ack);
   assign capture  = st && accept;
   assign sb_clear = in_drain && (ack || tmo);

   assign sb_addr_nxt = capture ? addr  : sb_addr;
   assign sb_data_nxt = capture ? wData : sb_data;

   store_buffer #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst),
      .capture    (capture),
      .clear      (sb_clear),
      .cap_addr   (addr),
      .cap_data   (wData),
      .lookup_addr(addr),
      .valid      (sb_valid),
      .sb_addr    (sb_addr),
      .sb_data    (sb_data),
      .hit        (sb_hit)
   );

   always_comb begin
      state_d = state_q;
      ld_d    = ld_q;
      cnt_d   = (in_drain || in_read) ? cnt_q + CNT_W'(1) : '0;
      case (state_q)
         IDLE: begin
            if (ld) begin
               if (!sb_hit) begin
                  state_d = sb_valid ? DRAIN : READ;
               end
            end else if (sb_valid || capture) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (ack || tmo) begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (ack) begin
               ld_d    = mem.memRData;
               state_d = DONE;
            end else if (tmo) begin
               ld_d    = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Bus outputs are registered from the next state so they hold steady until ack.
      req_d   = (state_d == DRAIN) || (state_d == READ);
      we_d    = (state_d == DRAIN);
      addr_d  = '0;
      wdata_d = '0;
      if (state_d == DRAIN) begin
         addr_d  = sb_addr_nxt;
         wdata_d = sb_data_nxt;
      end else if (state_d == READ) begin
         addr_d  = addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ld_q    <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ld_q    <= ld_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem.memReq   = req_q;
   assign mem.memWe    = we_q;
   assign mem.memAddr  = addr_q;
   assign mem.memWData = wdata_q;

   assign stall    = rst && ((ld && !sb_hit && (state_q != DONE)) || (st && !accept));
   assign misalign = rst && mis_raw;
   assign busErr   = tmo;

   always_comb begin
      ldData = '0;
      if (state_q == DONE) begin
         ldData = ld_q;
      end else if (ld && sb_hit) begin
         ldData = sb_data;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a transaction-level reference model.
module tb_mem_stage_ctrl;
   import mips_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 255;
   localparam int TX_NONE = 0;
   localparam int TX_WR   = 1;
   localparam int TX_RD   = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          memRead = 1'b0, memWrite = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wData = '0;
   logic          stall, misalign, busErr;
   logic [DW-1:0] ldData;

   mem_stage_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

   mem_stage_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clk     (clk),
      .rst     (rst),
      .memRead (memRead),
      .memWrite(memWrite),
      .addr    (addr),
      .wData   (wData),
      .stall   (stall),
      .ldData  (ldData),
      .misalign(misalign),
      .busErr  (busErr),
      .mem     (mem_if)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // Memory responder: acks ack_delay cycles after the request rises (<=0: never).
   int          ack_delay = 1;
   logic [31:0] rd_value = '0;
   int          req_age = 0;
   logic [31:0] last_wr_addr = '0, last_wr_data = '0;

   initial begin
      mem_if.memAck   = 1'b0;
      mem_if.memRData = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            mem_if.memAck = 1'b0;
            req_age = 0;
         end else if (mem_if.memAck) begin
            mem_if.memAck = 1'b0;
            req_age = 0;
         end else if (mem_if.memReq) begin
            req_age++;
            if (ack_delay >= 1 && req_age == ack_delay + 1) begin
               mem_if.memAck   = 1'b1;
               mem_if.memRData = rd_value;
               if (mem_if.memWe) begin
                  last_wr_addr = mem_if.memAddr;
                  last_wr_data = mem_if.memWData;
               end
            end
         end else begin
            req_age = 0;
         end
      end
   end

   // Reference model: buffer contents, outstanding bus transaction, pending load result.
   logic        m_sbv = 1'b0;
   logic [31:0] m_sba = '0, m_sbd = '0;
   int          m_txn = TX_NONE;
   logic [31:0] m_ta = '0, m_td = '0;
   int          m_age = 0;
   logic        m_done = 1'b0;
   logic [31:0] m_dd = '0;

   function automatic logic f_mis();
      return (memRead || memWrite) && (addr[1:0] != 2'b00);
   endfunction
   function automatic logic f_ld();
      return memRead && !f_mis();
   endfunction
   function automatic logic f_st();
      return memWrite && !f_mis();
   endfunction
   function automatic logic f_hit();
      return m_sbv && (m_sba == addr);
   endfunction
   function automatic logic f_accept();
      return !m_sbv || (m_txn == TX_WR && mem_if.memAck);
   endfunction
   function automatic logic f_tmo();
      return (m_txn != TX_NONE) && (m_age == TO - 1) && !mem_if.memAck;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_sbv = 1'b0; m_sba = '0; m_sbd = '0;
         m_txn = TX_NONE; m_ta = '0; m_td = '0; m_age = 0;
         m_done = 1'b0; m_dd = '0;
      end else begin
         logic ld, hit, cap, tmo, ack, was_idle;
         ld  = f_ld();
         hit = f_hit();
         cap = f_st() && f_accept();
         tmo = f_tmo();
         ack = mem_if.memAck;
         was_idle = (m_txn == TX_NONE) && !m_done;
         m_done = 1'b0;
         if (m_txn != TX_NONE) begin
            if (ack || tmo) begin
               if (m_txn == TX_WR) m_sbv = 1'b0;
               else begin
                  m_done = 1'b1;
                  m_dd   = ack ? mem_if.memRData : 32'h0;
               end
               m_txn = TX_NONE;
            end else begin
               m_age++;
            end
         end else if (was_idle) begin
            if (ld) begin
               if (!hit) begin
                  m_age = 0;
                  if (m_sbv) begin
                     m_txn = TX_WR; m_ta = m_sba; m_td = m_sbd;
                  end else begin
                     m_txn = TX_RD; m_ta = addr; m_td = '0;
                  end
               end
            end else if (m_sbv || cap) begin
               m_age = 0;
               m_txn = TX_WR;
               m_ta  = cap ? addr : m_sba;
               m_td  = cap ? wData : m_sbd;
            end
         end
         if (cap) begin
            m_sbv = 1'b1; m_sba = addr; m_sbd = wData;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_out_stall", stall, 0);
         chk("rst_out_misalign", misalign, 0);
         chk("rst_out_busErr", busErr, 0);
         chk("rst_out_memReq", mem_if.memReq, 0);
         chk("rst_out_ldData", ldData, 0);
      end else begin
         logic exp_stall;
         exp_stall = (f_ld() && !f_hit() && !m_done) || (f_st() && !f_accept());
         chk("model_stall", stall, exp_stall);
         chk("model_misalign", misalign, f_mis());
         chk("model_busErr", busErr, f_tmo());
         chk("model_memReq", mem_if.memReq, m_txn != TX_NONE);
         if (m_txn != TX_NONE) begin
            chk("model_memWe", mem_if.memWe, m_txn == TX_WR);
            chk("model_memAddr", mem_if.memAddr, m_ta);
            if (m_txn == TX_WR) chk("model_memWData", mem_if.memWData, m_td);
         end
         if (f_ld() && !exp_stall) chk("model_ldData", ldData, m_done ? m_dd : m_sbd);
         if (memRead && f_mis()) chk("model_ldData_mis", ldData, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic run_load(input logic [31:0] a, output int n, output logic [31:0] d);
      memRead = 1'b1;
      addr    = a;
      n       = 0;
      settle();
      while (stall && n < 600) begin
         n++;
         tick();
         settle();
      end
      if (n >= 600) begin
         n_fail++;
         $display("FAIL load_bound: stall still high after %0d cycles, required release", n);
      end
      d = ldData;
      tick();
      memRead = 1'b0;
   endtask

   initial begin
      int          n, rc;
      logic [31:0] d;

      #1 rst = 1'b0;
      memRead = 1'b1; addr = 32'h42;
      repeat (2) tick();
      settle();
      chk("rst_misalign_gated", misalign, 0);
      chk("rst_stall_gated", stall, 0);
      chk("rst_memReq", mem_if.memReq, 0);
      tick();
      rst = 1'b1; memRead = 1'b0; addr = '0;
      tick();

      // Posted store then forwarding hit during its drain
      ack_delay = 1;
      memWrite = 1'b1; addr = 32'h40; wData = 32'hDEADBEEF;
      settle();
      chk("store_no_stall", stall, 0);
      tick();
      memWrite = 1'b0; memRead = 1'b1; addr = 32'h40;
      settle();
      chk("drain_req", mem_if.memReq, 1);
      chk("drain_we", mem_if.memWe, 1);
      chk("drain_addr", mem_if.memAddr, 32'h40);
      chk("hit_stall", stall, 0);
      chk("hit_data", ldData, 32'hDEADBEEF);
      tick();
      memRead = 1'b0;
      tick();
      settle();
      chk("drain_idle_req", mem_if.memReq, 0);
      chk("drain_wr_addr", last_wr_addr, 32'h40);
      chk("drain_wr_data", last_wr_data, 32'hDEADBEEF);

      // Buffer now empty: plain load miss, 3 stall cycles
      rd_value = 32'h5555;
      run_load(32'h40, n, d);
      chk("miss_stall_cycles", n, 3);
      chk("miss_data", d, 32'h5555);

      // Load miss behind a draining store: 2 drain + 1 gap + 2 read stall cycles
      memWrite = 1'b1; addr = 32'h40; wData = 32'hCAFEF00D;
      tick();
      memWrite = 1'b0;
      rd_value = 32'h1234;
      run_load(32'h80, n, d);
      chk("drain_then_read_stalls", n, 5);
      chk("drain_then_read_data", d, 32'h1234);

      // Back-to-back stores: second captured in the drain-ack cycle
      ack_delay = 2;
      memWrite = 1'b1; addr = 32'h100; wData = 32'h11111111;
      settle();
      chk("st1_no_stall", stall, 0);
      tick();
      addr = 32'h104; wData = 32'h22222222;
      n = 0;
      settle();
      while (stall && n < 20) begin
         n++;
         tick();
         settle();
      end
      chk("st2_stall_cycles", n, 2);
      chk("st2_release_on_ack", mem_if.memAck, 1);
      tick();
      memWrite = 1'b0;
      settle();
      chk("st2_gap_idle", mem_if.memReq, 0);
      tick();
      settle();
      chk("st2_drain_req", mem_if.memReq, 1);
      chk("st2_drain_addr", mem_if.memAddr, 32'h104);
      chk("st2_drain_data", mem_if.memWData, 32'h22222222);
      repeat (3) tick();

      // Misaligned load and store
      memRead = 1'b1; addr = 32'h42;
      settle();
      chk("mis_ld_flag", misalign, 1);
      chk("mis_ld_stall", stall, 0);
      chk("mis_ld_data", ldData, 0);
      chk("mis_ld_noreq", mem_if.memReq, 0);
      tick();
      memRead = 1'b0; memWrite = 1'b1; addr = 32'h46; wData = 32'h77;
      settle();
      chk("mis_st_flag", misalign, 1);
      chk("mis_st_stall", stall, 0);
      tick();
      memWrite = 1'b0;
      settle();
      chk("mis_st_not_buffered", mem_if.memReq, 0);
      tick();

      // Read timeout
      ack_delay = -1;
      memRead = 1'b1; addr = 32'h200;
      settle();
      n = 0; rc = 0;
      while (n < 400) begin
         if (mem_if.memReq) rc++;
         if (busErr) break;
         n++;
         tick();
         settle();
      end
      chk("tmo_req_cycles", rc, TO);
      chk("tmo_cycle_stall", stall, 1);
      tick();
      settle();
      chk("tmo_pulse_end", busErr, 0);
      chk("tmo_ld_zero", ldData, 0);
      chk("tmo_resume", stall, 0);
      chk("tmo_req_drop", mem_if.memReq, 0);
      tick();
      memRead = 1'b0;
      tick();

      // Ack in the timeout cycle wins
      ack_delay = TO - 1;
      rd_value  = 32'hABCD;
      run_load(32'h204, n, d);
      chk("ack_at_tmo_stalls", n, TO + 1);
      chk("ack_at_tmo_data", d, 32'hABCD);
      tick();

      // Reset in the middle of a read
      ack_delay = -1;
      memRead = 1'b1; addr = 32'h300;
      repeat (5) tick();
      settle();
      chk("pre_rst_req", mem_if.memReq, 1);
      rst = 1'b0;
      #1;
      chk("rst_req_drop", mem_if.memReq, 0);
      chk("rst_stall_drop", stall, 0);
      chk("rst_ld_zero", ldData, 0);
      repeat (2) tick();
      memRead = 1'b0; rst = 1'b1;
      tick();
      settle();
      chk("post_rst_idle", mem_if.memReq, 0);
      ack_delay = 1;
      rd_value  = 32'h0F0F;
      run_load(32'h308, n, d);
      chk("post_rst_stalls", n, 3);
      chk("post_rst_data", d, 32'h0F0F);

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access controller sitting directly downstream of the EX/MEM pipeline register, between the pipeline and a multi-cycle data memory with a req/ack handshake. It converts MEM-stage load/store control into memory transactions, posts stores into a one-entry store buffer so they retire without stalling, and forwards buffered store data to matching loads. It stalls the whole pipeline while a load or blocked store waits on memory, and returns load data to the MEM/WB register.

## Interface
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: word width.
- `TIMEOUT_CYC`, default 255: maximum cycles `memReq` may stay high without `memAck` before the transaction aborts.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `memRead`  in  1  MEM-stage instruction is a load (from EX/MEM).
- `memWrite`  in  1  MEM-stage instruction is a store (from EX/MEM).
- `addr`  in  ADDR_W  effective address, the ALU result.
- `wData`  in  DATA_W  store data.
- `stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM, and inserts a bubble into MEM/WB.
- `ldData`  out  DATA_W  load result to MEM/WB; valid in the cycle the load advances.
- `misalign`  out  1  `addr[1:0] != 0` on a load or store; no access is made.
- `busErr`  out  1  one-cycle pulse on transaction timeout.
- `memReq`  out  1  memory request.
- `memWe`  out  1  1 = write, 0 = read; valid with `memReq`.
- `memAddr`  out  ADDR_W  request address.
- `memWData`  out  DATA_W  write data.
- `memAck`  in  1  one-cycle completion; arrives at least 1 cycle after `memReq` rises.
- `memRData`  in  DATA_W  read data; valid with `memAck`.

## Operation
- Store buffer state: `sbValid`, `sbAddr`, `sbData`.
- Hit = `sbValid && sbAddr == addr`.
- FSM states: IDLE, DRAIN, READ, DONE.
- **IDLE:** `memReq`=0.
  - Load hit: `ldData`=`sbData`, no stall, stay in IDLE.
  - Load miss with `sbValid`: go to DRAIN.
  - Load miss without `sbValid`: go to READ.
  - Otherwise, if `sbValid`: go to DRAIN (background drain).
- **DRAIN:** `memReq`=1, `memWe`=1, address/data taken from the buffer.
  - On `memAck`: clear `sbValid` and go to IDLE.
- **READ:** `memReq`=1, `memWe`=0, `memAddr`=`addr`.
  - `addr` is held stable because the pipeline is stalled.
  - On `memAck`: latch `memRData` and go to DONE.
- **DONE:** `stall`=0, `ldData`=latched data; next state is IDLE.
- Store acceptance: a store is captured into the buffer when `!sbValid` or (DRAIN && `memAck`).
  - Otherwise `stall`=1 until that condition holds.
  - A captured store sets `sbValid`=1 in the next cycle.
- `stall` = (load && !hit && state != DONE) || (store && !accept).
- Misaligned access:
  - `misalign`=1 (combinational), `stall`=0.
  - Store is not buffered; `ldData`=0.
- Timeout: a counter clears on entry to DRAIN or READ and increments each cycle `memReq` is high.
  - At `TIMEOUT_CYC` without ack: `busErr`=1 for that cycle.
  - From DRAIN: discard the buffer, go to IDLE.
  - From READ: latch 0, go to DONE.
  - Ack in the same cycle as timeout: ack wins, no `busErr`.
- Reset (`rst`=0): state IDLE, `sbValid`=0, counter 0, latched data 0.
  - All outputs are 0 while `rst` is low.
  - A transaction in flight at reset is abandoned; `memReq` drops immediately.

## Timing
- Load miss with buffer empty, ack in the cycle after req:
  - C0 IDLE, `stall`=1.
  - C1 READ, `memReq`=1.
  - C2 `memAck`, `stall`=1.
  - C3 DONE, `stall`=0, `ldData` valid.
  - Total: 3 stall cycles.
- Each additional ack wait cycle adds 1 stall cycle. A preceding drain adds its own duration plus 1 (the DRAIN→IDLE cycle).
- Load hit and accepted store: 0 stall cycles.
- `memReq`, `memWe`, `memAddr` and `memWData` are registered from state and are stable until ack.

## Structure
- Shared package `mips_pkg`:
  - `mem_state_t` enum (IDLE, DRAIN, READ, DONE).
  - `WORD_W` and the address-width constants.
- Sub-module `store_buffer`: the one-entry register, hit compare and capture/clear logic.
- The FSM and timeout counter stay in `mem_stage_ctrl`.

## Test plan
- Store to 0x40 data 0xDEADBEEF with buffer empty → `stall`=0; next cycle DRAIN with `memAddr`=0x40, `memWe`=1; ack → `sbValid`=0.
- Load 0x40 while buffer still holds 0x40/0xDEADBEEF → `stall`=0, `ldData`=0xDEADBEEF, no read issued.
- Load 0x80 with buffer holding 0x40 → drain write first, then read 0x80; memory returns 0x1234 → `ldData`=0x1234 in DONE. Stall spans the drain plus 3 cycles.
- Two back-to-back stores, first still draining → second stalls until the drain ack, then is captured in that ack cycle.
- Load 0x42 → `misalign`=1, `stall`=0, `ldData`=0, `memReq` stays 0.
- Read with `memAck` withheld → `busErr` pulses at cycle `TIMEOUT_CYC`, `ldData`=0, pipeline resumes. Repeat with `rst` asserted mid-READ → `memReq` drops and state returns to IDLE.
